// File: rtl/mul_para_a_arbiter_if.sv
// Requester / multiplier / result bundle for the shared-multiplier arbiter.
// master = requesters + multiplier + result consumer side, slave = arbiter.
interface mul_para_a_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic                   en;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*16-1:0]  req_data;
   logic [15:0]            mul_a;
   logic [22:0]            mul_p;
   logic                   res_valid;
   logic [ID_W-1:0]        res_id;
   logic [22:0]            res_data;
   logic [3:0]             inflight;

   modport master (
      output en, req_valid, req_data, mul_p,
      input  req_ready, mul_a, res_valid, res_id, res_data, inflight
   );

   modport slave (
      input  en, req_valid, req_data, mul_p,
      output req_ready, mul_a, res_valid, res_id, res_data, inflight
   );
endinterface

// File: rtl/mul_para_a_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined multiplier among
// NUM_REQ requesters. A tag pipeline carries the requester id alongside the
// operand so each product comes back labelled with its owner.
module mul_para_a_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = 3,
   parameter int ID_W        = $clog2(NUM_REQ)
) (
   input  logic clk,
   input  logic rst_n,
   mul_para_a_arbiter_if.slave bus
);

   logic [ID_W-1:0]                   r_ptr;
   logic [ID_W-1:0]                   w_gnt_id;
   logic [ID_W-1:0]                   w_ptr_nxt;
   logic                              w_found;
   logic                              w_hs;
   logic [15:0]                       r_mul_a;
   // Stage 0 is loaded together with mul_a; stage MUL_LATENCY lines up with
   // the product on mul_p, MUL_LATENCY edges after the operand was registered.
   logic [MUL_LATENCY:0]              r_vld_pipe;
   logic [MUL_LATENCY:0][ID_W-1:0]    r_id_pipe;
   logic                              r_res_valid;
   logic [ID_W-1:0]                   r_res_id;
   logic [22:0]                       r_res_data;
   logic [3:0]                        r_inflight;

   // Requester index at offset o from the pointer, wrapped at NUM_REQ.
   function automatic int wrap_idx(input logic [ID_W-1:0] p, input int o);
      int s;
      s = int'(p) + o;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return s;
   endfunction

   // Scan from the pointer upward; first valid requester wins.
   always_comb begin
      w_found  = 1'b0;
      w_gnt_id = '0;
      for (int o = 0; o < NUM_REQ; o++) begin
         if (!w_found && bus.req_valid[wrap_idx(r_ptr, o)]) begin
            w_found  = 1'b1;
            w_gnt_id = ID_W'(wrap_idx(r_ptr, o));
         end
      end
   end

   // No grants while disabled or held in reset.
   assign w_hs      = bus.en & w_found & rst_n;
   assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

   // One-hot ready to the winner only.
   always_comb begin
      bus.req_ready = '0;
      if (w_hs) bus.req_ready[w_gnt_id] = 1'b1;
   end

   // Operand register and round-robin pointer; both hold without a handshake
   // so the multiplier input does not toggle when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mul_a <= '0;
         r_ptr   <= '0;
      end else if (w_hs) begin
         r_mul_a <= bus.req_data[16*w_gnt_id +: 16];
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Tag pipeline: shifts every cycle, never stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         r_id_pipe  <= '0;
      end else begin
         r_vld_pipe[0] <= w_hs;
         r_id_pipe[0]  <= w_gnt_id;
         for (int i = 1; i <= MUL_LATENCY; i++) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_id_pipe[i]  <= r_id_pipe[i-1];
         end
      end
   end

   // Result register: capture product when its tag reaches the last stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_valid <= 1'b0;
         r_res_id    <= '0;
         r_res_data  <= '0;
      end else if (r_vld_pipe[MUL_LATENCY]) begin
         r_res_valid <= 1'b1;
         r_res_id    <= r_id_pipe[MUL_LATENCY];
         r_res_data  <= bus.mul_p;
      end else begin
         r_res_valid <= 1'b0;
      end
   end

   // Outstanding count: issue adds one, return (result capture) removes one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= '0;
      end else begin
         case ({w_hs, r_vld_pipe[MUL_LATENCY]})
            2'b10:   r_inflight <= r_inflight + 4'd1;
            2'b01:   r_inflight <= r_inflight - 4'd1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   assign bus.mul_a     = r_mul_a;
   assign bus.res_valid = r_res_valid;
   assign bus.res_id    = r_res_id;
   assign bus.res_data  = r_res_data;
   assign bus.inflight  = r_inflight;

endmodule

// File: tb/tb_mul_para_a_arbiter.sv
// Bench for mul_para_a_arbiter: 4 requesters, multiplier model P = A*5 with
// 3-cycle latency, scoreboard of expected {id, product} per handshake.
module tb_mul_para_a_arbiter;

   localparam int NR = 4;
   localparam int LAT = 3;

   typedef struct packed {
      logic [1:0]  id;
      logic [22:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   int   res_cnt = 0;
   exp_t sb[$];
   int   gnt_q[$];

   mul_para_a_arbiter_if #(.NUM_REQ(NR), .ID_W(2)) bus ();

   mul_para_a_arbiter #(.NUM_REQ(NR), .MUL_LATENCY(LAT), .ID_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Multiplier model: product valid LAT edges after mul_a is registered.
   logic [22:0] mp [LAT];
   always @(posedge clk) begin
      mp[0] <= 23'(bus.mul_a) * 23'd5;
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
   end
   assign bus.mul_p = mp[LAT-1];

   // Handshake monitor: push expected result, log grant, check data stability.
   logic [NR-1:0]    prev_vld = '0;
   logic [NR-1:0]    prev_rdy = '0;
   logic [NR*16-1:0] prev_dat = '0;
   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         for (int i = 0; i < NR; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               sb.push_back('{id: 2'(i), data: 23'(bus.req_data[16*i +: 16]) * 23'd5});
               gnt_q.push_back(i);
            end
            if (prev_vld[i] && !prev_rdy[i] && bus.req_valid[i] &&
                bus.req_data[16*i +: 16] !== prev_dat[16*i +: 16]) begin
               bad++;
               $display("FAIL data_stable req=%0d got=%h want=%h", i,
                        bus.req_data[16*i +: 16], prev_dat[16*i +: 16]);
            end
         end
      end
      prev_vld = bus.req_valid;
      prev_rdy = bus.req_ready;
      prev_dat = bus.req_data;
   end

   // Result monitor: pop and compare every res_valid.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.res_valid === 1'b1) begin
         exp_t e;
         res_cnt++;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected id=%0d data=%h", bus.res_id, bus.res_data);
         end else begin
            e = sb.pop_front();
            if (bus.res_id !== e.id || bus.res_data !== e.data) begin
               bad++;
               $display("FAIL sb_result got id=%0d data=%h want id=%0d data=%h",
                        bus.res_id, bus.res_data, e.id, e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req_valid = '0;
      step();
      step();
      sb.delete();
      gnt_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.en = 1'b1;
      for (int c = 0; c < 4; c++) begin
         bus.req_valid = 4'($urandom_range(1, 15));
         bus.req_data = {$urandom, $urandom};
         #1;
         total++;
         if (bus.req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready got=%b want=0000", bus.req_ready);
         end
         total++;
         if ({bus.mul_a, bus.res_valid, bus.res_id, bus.res_data, bus.inflight} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got mul_a=%h rv=%b id=%0d rd=%h inf=%0d want all 0",
                     bus.mul_a, bus.res_valid, bus.res_id, bus.res_data, bus.inflight);
         end
         step();
      end
      bus.req_valid = 4'b0010;
      bus.req_data = 64'h0;
      rst_n = 1'b1;
      #1;
      total++;
      if (bus.req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL reset_release_ready got=%b want=0010", bus.req_ready);
      end
      bus.req_valid = '0;
      step();
   endtask

   task automatic test_single();
      do_reset();
      bus.en = 1'b1;
      bus.req_data = {16'h0, 16'h0, 16'h0010, 16'h0};
      bus.req_valid = 4'b0010;
      step();
      bus.req_valid = '0;
      for (int c = 0; c < 4; c++) begin
         total++;
         if (bus.inflight !== 4'd1 || bus.res_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_wait c=%0d got inf=%0d rv=%b want inf=1 rv=0",
                     c, bus.inflight, bus.res_valid);
         end
         step();
      end
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 ||
          bus.res_data !== 23'h000050 || bus.inflight !== 4'd0) begin
         bad++;
         $display("FAIL single_result got rv=%b id=%0d d=%h inf=%0d want rv=1 id=1 d=000050 inf=0",
                  bus.res_valid, bus.res_id, bus.res_data, bus.inflight);
      end
      step();
      total++;
      if (bus.res_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_one_shot got rv=%b want 0", bus.res_valid);
      end
   endtask

   task automatic test_saturation();
      int rc0;
      do_reset();
      rc0 = res_cnt;
      bus.en = 1'b1;
      bus.req_data = {16'd4, 16'd3, 16'd2, 16'd1};
      bus.req_valid = 4'b1111;
      for (int n = 1; n <= 12; n++) begin
         step();
         total++;
         if (bus.inflight !== 4'((n < 4) ? n : 4)) begin
            bad++;
            $display("FAIL sat_inflight n=%0d got=%0d want=%0d", n, bus.inflight, (n < 4) ? n : 4);
         end
         if (n >= 5) begin
            total++;
            if (bus.res_valid !== 1'b1) begin
               bad++;
               $display("FAIL sat_b2b n=%0d got rv=%b want 1", n, bus.res_valid);
            end
         end
      end
      bus.req_valid = '0;
      repeat (5) step();
      total++;
      if (bus.inflight !== 4'd0 || res_cnt - rc0 != 12) begin
         bad++;
         $display("FAIL sat_drain got inf=%0d results=%0d want inf=0 results=12",
                  bus.inflight, res_cnt - rc0);
      end
      total++;
      if (gnt_q.size() != 12) begin
         bad++;
         $display("FAIL sat_grant_count got=%0d want=12", gnt_q.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            if (gnt_q[i] != i % 4) begin
               bad++;
               $display("FAIL sat_grant_order i=%0d got=%0d want=%0d", i, gnt_q[i], i % 4);
            end
         end
      end
   endtask

   task automatic test_fairness();
      int exp_g[8];
      exp_g = '{0, 2, 0, 2, 3, 0, 2, 3};
      do_reset();
      bus.en = 1'b1;
      bus.req_data = {16'h0300, 16'h0, 16'h0200, 16'h0100};
      bus.req_valid = 4'b0101;
      repeat (4) step();
      bus.req_valid = 4'b1101;
      repeat (4) step();
      bus.req_valid = '0;
      repeat (6) step();
      total++;
      if (gnt_q.size() != 8) begin
         bad++;
         $display("FAIL fair_grant_count got=%0d want=8", gnt_q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (gnt_q[i] != exp_g[i]) begin
               bad++;
               $display("FAIL fair_grant_order i=%0d got=%0d want=%0d", i, gnt_q[i], exp_g[i]);
            end
         end
      end
   endtask

   task automatic test_enable();
      int rc0;
      do_reset();
      bus.en = 1'b1;
      bus.req_data = {16'd4, 16'd3, 16'd2, 16'd1};
      bus.req_valid = 4'b1111;
      repeat (3) step();
      bus.en = 1'b0;
      #1;
      total++;
      if (bus.req_ready !== 4'b0000 || bus.inflight !== 4'd3) begin
         bad++;
         $display("FAIL en_off got rdy=%b inf=%0d want rdy=0000 inf=3", bus.req_ready, bus.inflight);
      end
      rc0 = res_cnt;
      repeat (7) step();
      total++;
      if (res_cnt - rc0 != 3 || bus.inflight !== 4'd0) begin
         bad++;
         $display("FAIL en_drain got results=%0d inf=%0d want results=3 inf=0",
                  res_cnt - rc0, bus.inflight);
      end
      bus.en = 1'b1;
      #1;
      total++;
      if (bus.req_ready !== 4'b1000) begin
         bad++;
         $display("FAIL en_resume got rdy=%b want=1000", bus.req_ready);
      end
      step();
      bus.req_valid = '0;
      repeat (6) step();
      total++;
      if (gnt_q.size() != 4 || gnt_q[3] != 3) begin
         bad++;
         $display("FAIL en_grants got count=%0d want 4 ending in 3", gnt_q.size());
      end
   endtask

   task automatic test_midflight_reset();
      do_reset();
      bus.en = 1'b1;
      bus.req_data = {16'h0, 16'h0, 16'd9, 16'd7};
      bus.req_valid = 4'b0011;
      repeat (2) step();
      bus.req_valid = '0;
      total++;
      if (bus.inflight !== 4'd2) begin
         bad++;
         $display("FAIL mid_pre got inf=%0d want=2", bus.inflight);
      end
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      total++;
      if ({bus.mul_a, bus.res_valid, bus.res_id, bus.res_data, bus.inflight} !== '0 ||
          bus.req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL mid_clear got mul_a=%h rv=%b inf=%0d rdy=%b want all 0",
                  bus.mul_a, bus.res_valid, bus.inflight, bus.req_ready);
      end
      #9;
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         total++;
         if (bus.res_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_stale c=%0d got rv=%b want 0", c, bus.res_valid);
         end
      end
      total++;
      if (bus.inflight !== 4'd0) begin
         bad++;
         $display("FAIL mid_inflight got=%0d want=0", bus.inflight);
      end
   endtask

   initial begin
      bus.en = 1'b0;
      bus.req_valid = '0;
      bus.req_data = '0;
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      test_reset();
      test_single();
      test_saturation();
      test_fairness();
      test_enable();
      test_midflight_reset();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
